term_sum_sequencer: RTL and testbench
=====================================

TERM_SUM_SEQUENCER -- requirements
Module: term_sum_sequencer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 32, IEEE-754 single word width; MAX_TERMS, 64, maximum terms per expression; TIMEOUT_CYCLES, 65535, per-handshake wait limit.
REQ-002 clock  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 sum_start  input  1  single-cycle request to evaluate one expression.
REQ-005 num_terms  input  $clog2(MAX_TERMS+1)  term count, sampled with sum_start.
REQ-006 term_start  output  1  single-cycle launch pulse to the term accumulator.
REQ-007 term_index  output  $clog2(MAX_TERMS)  index of the term being evaluated.
REQ-008 term_value  input  DATA_WIDTH  term result; valid with term_ready.
REQ-009 term_ready  input  1  term result strobe.
REQ-010 add_start  output  1  single-cycle request to the shared FP adder.
REQ-011 operand_a, operand_b  output  DATA_WIDTH  adder operands, stable from add_start until add_data_ready.
REQ-012 add_result  input  DATA_WIDTH; add_data_ready  input  1  adder result and strobe.
REQ-013 sum_value  output  DATA_WIDTH  final sum, held until next sum_ready.
REQ-014 sum_ready  output  1  single-cycle completion pulse.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 timeout_error  output  1  single-cycle pulse on watchdog abort.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT_TERM, ADD, WAIT_ADD, DONE.
REQ-018 IDLE: on sum_start, latch num_terms, clear term_index and first_flag=1; go DONE if num_terms==0, else LAUNCH.
REQ-019 LAUNCH: term_start=1 for exactly this cycle, then WAIT_TERM.
REQ-020 WAIT_TERM: on term_ready, capture term_value; if first_flag, load accumulator directly (no adder use) and clear first_flag, else go ADD.
REQ-021 After a first-term load: LAUNCH if term_index+1 < latched count (incrementing term_index), else DONE.
REQ-022 ADD: add_start=1 one cycle, operand_a=accumulator, operand_b=captured term; then WAIT_ADD.
REQ-023 WAIT_ADD: on add_data_ready, accumulator<=add_result; then LAUNCH (term_index+1) or DONE per REQ-021 rule.
REQ-024 DONE: sum_value<=accumulator (32'h0000_0000 when count is 0), sum_ready=1 one cycle, return IDLE.
REQ-025 All outputs SHALL be registered; term_start, add_start, sum_ready, timeout_error never high two consecutive cycles.
REQ-026 Latency SHALL be: IDLE->term_start 1 cycle; term_ready->next term_start 1 cycle (first term) or 2 cycles + adder latency; last strobe->sum_ready 1 cycle (first term) or 1 cycle after add_data_ready.
REQ-027 sum_start while busy SHALL be ignored; term_ready outside WAIT_TERM and add_data_ready outside WAIT_ADD SHALL be ignored.
REQ-028 num_terms > MAX_TERMS SHALL be saturated to MAX_TERMS.
REQ-029 Watchdog: counter cleared on entering WAIT_TERM/WAIT_ADD; reaching TIMEOUT_CYCLES pulses timeout_error, returns IDLE without sum_ready, sum_value unchanged.
REQ-030 Strobe arriving in the same cycle the watchdog expires SHALL be accepted (strobe wins).

Reset
REQ-031 Reset SHALL force IDLE, all outputs 0, accumulator 0, counters 0, regardless of state; in-flight evaluation is abandoned with no sum_ready.
REQ-032 First sum_start after reset deassertion SHALL be accepted normally.

Structure
REQ-033 State enum and the zero constant SHALL live in shared package term_sum_pkg.
REQ-034 Watchdog SHALL be sub-module term_sum_watchdog (clear, enable, expire).

Verification
REQ-035 num_terms=3, terms 3F800000, 40000000, 40400000, adder model 4-cycle latency -> sum_value=40C00000 (6.0), one sum_ready, two add_start pulses.
REQ-036 num_terms=0 -> sum_ready one cycle after sum_start, sum_value=00000000, no term_start.
REQ-037 num_terms=1, term C0000000 -> sum_value=C0000000, no add_start.
REQ-038 TIMEOUT_CYCLES=16, term_ready withheld -> timeout_error on 16th wait cycle, no sum_ready, busy low next cycle.
REQ-039 sum_start repeated while busy plus spurious term_ready during WAIT_ADD -> ignored, result identical to REQ-035.
REQ-040 reset asserted mid WAIT_ADD -> outputs 0 asynchronously; new num_terms=2 run (3F800000+3F800000) -> 40000000.

Source files
------------

// File: rtl/term_sum_sequencer_pkg.sv
// term_sum_pkg
// Shared definitions for the term-sum sequencer: the FSM state encoding,
// the IEEE-754 zero constant used to seed the accumulator, and a helper
// that tells whether a state is one of the two handshake-wait states the
// watchdog supervises.
package term_sum_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_LAUNCH    = 3'd1;
    localparam state_t ST_WAIT_TERM = 3'd2;
    localparam state_t ST_ADD       = 3'd3;
    localparam state_t ST_WAIT_ADD  = 3'd4;
    localparam state_t ST_DONE      = 3'd5;

    // +0.0 in single precision; also the reported sum of an empty expression.
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    function automatic logic is_wait_state(input state_t s);
        return (s == ST_WAIT_TERM) || (s == ST_WAIT_ADD);
    endfunction

endpackage

// File: rtl/term_sum_sequencer_if.sv
// term_sum_sequencer_if
// Bundles every non-clock/reset signal of the term-sum sequencer.
//   sum_start/num_terms               : expression request (environment -> sequencer)
//   term_start/term_index             : term accumulator launch (sequencer -> environment)
//   term_value/term_ready             : term result strobe (environment -> sequencer)
//   add_start/operand_a/operand_b     : shared FP adder request (sequencer -> environment)
//   add_result/add_data_ready         : adder result strobe (environment -> sequencer)
//   sum_value/sum_ready/busy/timeout_error : status and result (sequencer -> environment)
// Modport master is the sequencer side, slave is the environment side.
interface term_sum_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_TERMS  = 64
);
    localparam int COUNT_W = $clog2(MAX_TERMS + 1);
    localparam int IDX_W   = $clog2(MAX_TERMS);

    logic                  sum_start;
    logic [COUNT_W-1:0]    num_terms;
    logic                  term_start;
    logic [IDX_W-1:0]      term_index;
    logic [DATA_WIDTH-1:0] term_value;
    logic                  term_ready;
    logic                  add_start;
    logic [DATA_WIDTH-1:0] operand_a;
    logic [DATA_WIDTH-1:0] operand_b;
    logic [DATA_WIDTH-1:0] add_result;
    logic                  add_data_ready;
    logic [DATA_WIDTH-1:0] sum_value;
    logic                  sum_ready;
    logic                  busy;
    logic                  timeout_error;

    modport master (
        input  sum_start, num_terms, term_value, term_ready, add_result, add_data_ready,
        output term_start, term_index, add_start, operand_a, operand_b,
               sum_value, sum_ready, busy, timeout_error
    );

    modport slave (
        output sum_start, num_terms, term_value, term_ready, add_result, add_data_ready,
        input  term_start, term_index, add_start, operand_a, operand_b,
               sum_value, sum_ready, busy, timeout_error
    );

endinterface

// File: rtl/term_sum_sequencer_watchdog.sv
// term_sum_watchdog
// Counts cycles spent waiting for a handshake strobe.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   clear        : zero the counter (held while not waiting)
//   enable       : count this cycle (high while waiting)
//   expire       : combinational, high in the TIMEOUT_CYCLES-th enabled cycle
//                  after a clear
module term_sum_watchdog #(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The count equals the number of completed wait cycles, so the value
    // LIMIT is seen during the final permitted wait cycle.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CW'(1);
        end
    end

    assign expire = enable && (count_q == LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/term_sum_sequencer.sv
// term_sum_sequencer
// Evaluates a sum of up to MAX_TERMS floating-point terms. Each term is
// requested from an external term accumulator; the first term seeds the
// accumulator directly and every following term is folded in through a
// shared external FP adder. A watchdog aborts any handshake that stalls
// for TIMEOUT_CYCLES cycles.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus          : term_sum_sequencer_if.master (request, term, adder and
//                  status signals; all outputs are registered)
module term_sum_sequencer
    import term_sum_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_TERMS      = 64,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clock,
    input  logic                  reset,
    term_sum_sequencer_if.master  bus
);
    localparam int COUNT_W = $clog2(MAX_TERMS + 1);
    localparam int IDX_W   = $clog2(MAX_TERMS);
    localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_TERMS);

    state_t                state_q, state_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [IDX_W-1:0]      index_q, index_d;
    logic                  first_q, first_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
    logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
    logic [DATA_WIDTH-1:0] sum_value_q, sum_value_d;
    logic                  term_start_q, term_start_d;
    logic                  add_start_q, add_start_d;
    logic                  sum_ready_q, sum_ready_d;
    logic                  busy_q, busy_d;
    logic                  timeout_q, timeout_d;

    logic waiting;
    logic expire;
    logic more_terms;

    assign waiting = is_wait_state(state_q);

    term_sum_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (!waiting),
        .enable (waiting),
        .expire (expire)
    );

    // True when the term just completed is not the last one.
    assign more_terms = (COUNT_W'(index_q) + COUNT_W'(1)) < count_q;

    // Next-state logic. A strobe is tested before the watchdog so that a
    // strobe arriving in the expiry cycle is still accepted.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        index_d   = index_q;
        first_d   = first_q;
        acc_d     = acc_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        timeout_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.sum_start) begin
                    count_d = (bus.num_terms > MAX_COUNT) ? MAX_COUNT : bus.num_terms;
                    index_d = '0;
                    first_d = 1'b1;
                    acc_d   = DATA_WIDTH'(FP_ZERO);
                    state_d = (bus.num_terms == '0) ? ST_DONE : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT_TERM;
            end
            ST_WAIT_TERM: begin
                if (bus.term_ready) begin
                    if (first_q) begin
                        acc_d   = bus.term_value;
                        first_d = 1'b0;
                        if (more_terms) begin
                            index_d = index_q + IDX_W'(1);
                            state_d = ST_LAUNCH;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        op_a_d  = acc_q;
                        op_b_d  = bus.term_value;
                        state_d = ST_ADD;
                    end
                end else if (expire) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            ST_ADD: begin
                state_d = ST_WAIT_ADD;
            end
            ST_WAIT_ADD: begin
                if (bus.add_data_ready) begin
                    acc_d = bus.add_result;
                    if (more_terms) begin
                        index_d = index_q + IDX_W'(1);
                        state_d = ST_LAUNCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (expire) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered pulses line
    // up with the one-cycle LAUNCH, ADD and DONE states.
    always_comb begin
        term_start_d = (state_d == ST_LAUNCH);
        add_start_d  = (state_d == ST_ADD);
        sum_ready_d  = (state_d == ST_DONE);
        busy_d       = (state_d != ST_IDLE);
        sum_value_d  = (state_d == ST_DONE) ? acc_d : sum_value_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            index_q      <= '0;
            first_q      <= 1'b0;
            acc_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            sum_value_q  <= '0;
            term_start_q <= 1'b0;
            add_start_q  <= 1'b0;
            sum_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            index_q      <= index_d;
            first_q      <= first_d;
            acc_q        <= acc_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            sum_value_q  <= sum_value_d;
            term_start_q <= term_start_d;
            add_start_q  <= add_start_d;
            sum_ready_q  <= sum_ready_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
        end
    end

    assign bus.term_start    = term_start_q;
    assign bus.term_index    = index_q;
    assign bus.add_start     = add_start_q;
    assign bus.operand_a     = op_a_q;
    assign bus.operand_b     = op_b_q;
    assign bus.sum_value     = sum_value_q;
    assign bus.sum_ready     = sum_ready_q;
    assign bus.busy          = busy_q;
    assign bus.timeout_error = timeout_q;

endmodule

// File: tb/tb_term_sum_sequencer.sv
// tb_term_sum_sequencer
// Scoreboard bench for term_sum_sequencer. Each accepted request pushes
// its expected completion (sum or watchdog abort) into a queue; a monitor
// pops and compares whenever sum_ready or timeout_error appears. A term
// source answers term_start from a queue of directed term values, and an
// adder model answers add_start after a fixed latency using a table of
// hand-computed single-precision sums.
module tb_term_sum_sequencer;

    localparam int DATA_WIDTH     = 32;
    localparam int MAX_TERMS      = 64;
    localparam int TIMEOUT_CYCLES = 16;
    localparam int ADD_LAT        = 4;
    localparam int TERM_DELAY     = 2;

    typedef struct {
        bit          timeout;
        logic [31:0] value;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    term_sum_sequencer_if #(.DATA_WIDTH(DATA_WIDTH), .MAX_TERMS(MAX_TERMS)) bus ();

    term_sum_sequencer #(
        .DATA_WIDTH     (DATA_WIDTH),
        .MAX_TERMS      (MAX_TERMS),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    int errors = 0;
    int checks = 0;

    exp_t        sb[$];
    logic [31:0] term_vals[$];

    bit withhold = 0;
    bit spur_en  = 0;
    bit aborted  = 0;

    int exp_index   = 0;
    int term_starts = 0;
    int add_starts  = 0;
    int last_ts_cyc = 0;

    logic        resp_ready = 1'b0;
    logic        spur_ready = 1'b0;
    logic [31:0] resp_val   = 32'h0;
    logic [31:0] spur_val   = 32'h7F7F7F7F;

    assign bus.term_ready = resp_ready | spur_ready;
    assign bus.term_value = spur_ready ? spur_val : resp_val;

    bit prev_ts = 0, prev_as = 0, prev_sr = 0, prev_te = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Hand-computed single-precision sums for every operand pair the
    // directed vectors produce.
    function automatic logic [31:0] fpAdd(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3F800000, 32'h40000000}: return 32'h40400000;
            {32'h40400000, 32'h40400000}: return 32'h40C00000;
            {32'h3F800000, 32'h3F800000}: return 32'h40000000;
            {32'h00000000, 32'h00000000}: return 32'h00000000;
            default:                      return 32'hDEADBEEF;
        endcase
    endfunction

    // Pulse counting and single-cycle width of every strobe output.
    always @(negedge clock) begin
        if (bus.term_start) begin
            term_starts++;
            last_ts_cyc = cyc;
            checkOutput("term_start single cycle", 32'(prev_ts), 32'h0);
        end
        if (bus.add_start) begin
            add_starts++;
            checkOutput("add_start single cycle", 32'(prev_as), 32'h0);
        end
        if (bus.sum_ready) checkOutput("sum_ready single cycle", 32'(prev_sr), 32'h0);
        if (bus.timeout_error) checkOutput("timeout_error single cycle", 32'(prev_te), 32'h0);
        prev_ts = bus.term_start;
        prev_as = bus.add_start;
        prev_sr = bus.sum_ready;
        prev_te = bus.timeout_error;
    end

    // Scoreboard monitor.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && (bus.sum_ready || bus.timeout_error)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected completion: actual sum_ready=%0b timeout_error=%0b required none",
                         bus.sum_ready, bus.timeout_error);
            end else begin
                e = sb.pop_front();
                checkOutput("completion is timeout", 32'(bus.timeout_error), 32'(e.timeout));
                checkOutput("sum_value", bus.sum_value, e.value);
                if (e.timeout) begin
                    checkOutput("no sum_ready on timeout", 32'(bus.sum_ready), 32'h0);
                    checkOutput("busy low on timeout", 32'(bus.busy), 32'h0);
                    checkOutput("timeout latency", 32'(cyc - last_ts_cyc), 32'(TIMEOUT_CYCLES + 1));
                end
            end
        end
    end

    // Term source: answers each term_start with the next queued value.
    initial begin
        logic [31:0] v;
        forever begin
            @(negedge clock);
            if (bus.term_start && !withhold) begin
                checkOutput("term_index", 32'(bus.term_index), 32'(exp_index));
                exp_index++;
                if (term_vals.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL term source: actual term_start at index %0d, required no further term",
                             bus.term_index);
                    v = 32'h0;
                end else begin
                    v = term_vals.pop_front();
                end
                repeat (TERM_DELAY) @(posedge clock);
                #1;
                resp_val   = v;
                resp_ready = 1'b1;
                @(posedge clock);
                #1;
                resp_ready = 1'b0;
            end
        end
    end

    // Adder model with fixed latency; optionally injects a stray
    // term_ready in the first cycle of WAIT_ADD.
    initial begin
        logic [31:0] a, b, res;
        forever begin
            @(negedge clock);
            if (bus.add_start) begin
                a   = bus.operand_a;
                b   = bus.operand_b;
                res = fpAdd(a, b);
                for (int k = 1; k <= ADD_LAT; k++) begin
                    @(posedge clock);
                    #1;
                    spur_ready = spur_en && (k == 1);
                end
                if (!aborted) begin
                    checkOutput("operand_a stable", bus.operand_a, a);
                    checkOutput("operand_b stable", bus.operand_b, b);
                end
                bus.add_result     = res;
                bus.add_data_ready = 1'b1;
                @(posedge clock);
                #1;
                bus.add_data_ready = 1'b0;
            end
        end
    end

    task automatic applyStimulus(input int n, input logic [31:0] expected, input bit expect_timeout);
        exp_t e;
        e.timeout = expect_timeout;
        e.value   = expected;
        exp_index = 0;
        @(posedge clock);
        #1;
        sb.push_back(e);
        bus.num_terms = 7'(n);
        bus.sum_start = 1'b1;
        @(posedge clock);
        #1;
        bus.sum_start = 1'b0;
        bus.num_terms = 7'(0);
    endtask

    task automatic pulseStartWhileBusy();
        @(posedge clock);
        #1;
        bus.num_terms = 7'(0);
        bus.sum_start = 1'b1;
        @(posedge clock);
        #1;
        bus.sum_start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clock);
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: actual no completion after %0d cycles, required completion", name, budget);
            sb.delete();
        end
        repeat (8) @(posedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global time limit: actual still running, required finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int ts0, as0, k;
        bus.sum_start      = 1'b0;
        bus.num_terms      = 7'(0);
        bus.add_result     = 32'h0;
        bus.add_data_ready = 1'b0;

        // Reset state.
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset busy",          32'(bus.busy),          32'h0);
        checkOutput("reset sum_ready",     32'(bus.sum_ready),     32'h0);
        checkOutput("reset term_start",    32'(bus.term_start),    32'h0);
        checkOutput("reset add_start",     32'(bus.add_start),     32'h0);
        checkOutput("reset timeout_error", 32'(bus.timeout_error), 32'h0);
        checkOutput("reset sum_value",     bus.sum_value,          32'h0);
        checkOutput("reset term_index",    32'(bus.term_index),    32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Three terms: 1.0 + 2.0 + 3.0 = 6.0.
        $display("[TB] three-term sum");
        ts0 = term_starts; as0 = add_starts;
        term_vals = {32'h3F800000, 32'h40000000, 32'h40400000};
        applyStimulus(3, 32'h40C00000, 1'b0);
        waitDone(200, "three-term sum");
        checkOutput("three-term term_start count", 32'(term_starts - ts0), 32'd3);
        checkOutput("three-term add_start count",  32'(add_starts - as0),  32'd2);

        // Empty expression.
        $display("[TB] zero-term sum");
        ts0 = term_starts;
        applyStimulus(0, 32'h00000000, 1'b0);
        @(negedge clock);
        checkOutput("zero-term sum_ready latency", 32'(bus.sum_ready), 32'h1);
        waitDone(50, "zero-term sum");
        checkOutput("zero-term term_start count", 32'(term_starts - ts0), 32'd0);

        // Single term bypasses the adder.
        $display("[TB] one-term sum");
        ts0 = term_starts; as0 = add_starts;
        term_vals = {32'hC0000000};
        applyStimulus(1, 32'hC0000000, 1'b0);
        waitDone(50, "one-term sum");
        checkOutput("one-term term_start count", 32'(term_starts - ts0), 32'd1);
        checkOutput("one-term add_start count",  32'(add_starts - as0),  32'd0);

        // Term never arrives: watchdog abort, previous sum kept.
        $display("[TB] watchdog abort");
        withhold = 1;
        ts0 = term_starts; as0 = add_starts;
        applyStimulus(2, 32'hC0000000, 1'b1);
        waitDone(100, "watchdog abort");
        withhold = 0;
        checkOutput("sum_value held after timeout", bus.sum_value, 32'hC0000000);
        checkOutput("timeout term_start count", 32'(term_starts - ts0), 32'd1);

        // Repeated sum_start while busy and a stray term_ready in WAIT_ADD.
        $display("[TB] ignored requests and strobes");
        spur_en = 1;
        ts0 = term_starts; as0 = add_starts;
        term_vals = {32'h3F800000, 32'h40000000, 32'h40400000};
        applyStimulus(3, 32'h40C00000, 1'b0);
        repeat (3) @(posedge clock);
        pulseStartWhileBusy();
        repeat (6) @(posedge clock);
        pulseStartWhileBusy();
        waitDone(200, "ignored requests");
        spur_en = 0;
        checkOutput("ignored term_start count", 32'(term_starts - ts0), 32'd3);
        checkOutput("ignored add_start count",  32'(add_starts - as0),  32'd2);

        // Reset in the middle of WAIT_ADD, then a fresh run.
        $display("[TB] reset during WAIT_ADD");
        as0 = add_starts;
        term_vals = {32'h3F800000, 32'h40000000, 32'h40400000};
        applyStimulus(3, 32'h40C00000, 1'b0);
        k = 0;
        while (add_starts == as0 && k < 100) begin
            @(negedge clock);
            k++;
        end
        checkOutput("reset test reached ADD", 32'(add_starts - as0), 32'd1);
        @(posedge clock);
        #3;
        aborted = 1;
        reset   = 1'b1;
        #1;
        checkOutput("async reset busy",       32'(bus.busy),       32'h0);
        checkOutput("async reset sum_value",  bus.sum_value,       32'h0);
        checkOutput("async reset operand_a",  bus.operand_a,       32'h0);
        checkOutput("async reset term_index", 32'(bus.term_index), 32'h0);
        sb.delete();
        term_vals.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clock);
        aborted = 0;
        term_vals = {32'h3F800000, 32'h3F800000};
        applyStimulus(2, 32'h40000000, 1'b0);
        waitDone(100, "run after reset");

        // Oversized count saturates to MAX_TERMS.
        $display("[TB] num_terms saturation");
        ts0 = term_starts; as0 = add_starts;
        for (int i = 0; i < MAX_TERMS; i++) term_vals.push_back(32'h00000000);
        applyStimulus(100, 32'h00000000, 1'b0);
        waitDone(2000, "saturation");
        checkOutput("saturated term_start count", 32'(term_starts - ts0), 32'(MAX_TERMS));
        checkOutput("saturated add_start count",  32'(add_starts - as0),  32'(MAX_TERMS - 1));

        repeat (5) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
